// File: rtl/uart_line_monitor_bridge_pkg.sv
// Shared constants and helpers for the UART line monitor bridge.
// Provides the clock rate, the default timing constants derived from it, the
// default idle level of the lines, and a width helper for counters.
package uart_bridge_pkg;

  localparam int unsigned CLK_HZ                   = 12_000_000;
  localparam int unsigned DEFAULT_STRETCH_CYCLES   = CLK_HZ / 10;  // 100 ms
  localparam int unsigned DEFAULT_BREAK_CYCLES     = CLK_HZ / 5;   // 200 ms
  localparam int unsigned DEFAULT_HEARTBEAT_CYCLES = CLK_HZ / 2;   // 500 ms half-period
  localparam logic [3:0]  DEFAULT_IDLE_LEVEL       = 4'b1111;

  // Number of bits needed to hold values 0..max_val (at least 1).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_line_monitor_bridge_if.sv
// Forwarded line bundle between board pins and the uC header.
//   line_in  : raw lines from their sources (driven by master)
//   line_out : forwarded lines to their sinks (driven by slave, the bridge)
interface uart_line_monitor_bridge_if #(
  parameter int unsigned NUM_LINES = 4
) ();
  logic [NUM_LINES-1:0] line_in;
  logic [NUM_LINES-1:0] line_out;

  modport master (output line_in, input line_out);
  modport slave  (input line_in, output line_out);
endinterface

// File: rtl/uart_line_monitor_bridge_line.sv
// Single-line monitor: input synchroniser, edge detector, activity stretcher
// and sticky stuck-line detector.
//   clk, rst     : clock, asynchronous active-high reset
//   line_raw     : unsynchronised line
//   clear        : synchronised level; clears the sticky stuck flag
//   activity_led : 1 while an edge was seen within STRETCH_CYCLES
//   stuck        : sticky flag, set after BREAK_CYCLES continuous non-idle cycles
module uart_line_monitor
  import uart_bridge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter logic        IDLE_BIT       = 1'b1,
  parameter int unsigned STRETCH_CYCLES = DEFAULT_STRETCH_CYCLES,
  parameter int unsigned BREAK_CYCLES   = DEFAULT_BREAK_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic line_raw,
  input  logic clear,
  output logic activity_led,
  output logic stuck
);

  localparam int unsigned ACT_W = cnt_width(STRETCH_CYCLES);
  localparam int unsigned BRK_W = cnt_width(BREAK_CYCLES);
  localparam logic [ACT_W-1:0] ACT_LOAD = ACT_W'(STRETCH_CYCLES);
  localparam logic [BRK_W-1:0] BRK_MAX  = BRK_W'(BREAK_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   line_s;
  logic                   edge_pulse;
  logic [ACT_W-1:0]       act_cnt, act_next;
  logic [BRK_W-1:0]       brk_cnt, brk_next;

  assign line_s     = sync_q[SYNC_STAGES-1];
  assign edge_pulse = line_s ^ prev_q;

  // Reload takes priority over decrement so back-to-back edges never gap the LED.
  always_comb begin
    act_next = act_cnt;
    if (edge_pulse)
      act_next = ACT_LOAD;
    else if (act_cnt != '0)
      act_next = act_cnt - 1'b1;
  end

  always_comb begin
    brk_next = brk_cnt;
    if (line_s == IDLE_BIT)
      brk_next = '0;
    else if (brk_cnt != BRK_MAX)
      brk_next = brk_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q       <= {SYNC_STAGES{IDLE_BIT}};
      prev_q       <= IDLE_BIT;
      act_cnt      <= '0;
      brk_cnt      <= '0;
      activity_led <= 1'b0;
      stuck        <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], line_raw};
      prev_q       <= line_s;
      act_cnt      <= act_next;
      brk_cnt      <= brk_next;
      activity_led <= (act_next != '0);
      // Set wins over clear: a line still held re-flags on the same edge.
      if (brk_next == BRK_MAX)
        stuck <= 1'b1;
      else if (clear)
        stuck <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_line_monitor_bridge.sv
// Zero-latency UART/handshake pass-through with per-line monitoring.
//   clock_12mhz   : system clock
//   reset         : asynchronous active-high reset
//   lines         : forwarded line bundle (line_in -> line_out)
//   isolate       : async level; 1 forces all line_out to IDLE_LEVEL
//   stuck_clear   : async level; clears sticky stuck flags
//   activity_led  : per-line stretched activity indication
//   stuck         : per-line sticky stuck-line flags
//   heartbeat_led : toggles every HEARTBEAT_CYCLES
module uart_line_monitor_bridge
  import uart_bridge_pkg::*;
#(
  parameter int unsigned          NUM_LINES        = 4,
  parameter int unsigned          SYNC_STAGES      = 2,
  parameter logic [NUM_LINES-1:0] IDLE_LEVEL       = DEFAULT_IDLE_LEVEL,
  parameter int unsigned          STRETCH_CYCLES   = DEFAULT_STRETCH_CYCLES,
  parameter int unsigned          BREAK_CYCLES     = DEFAULT_BREAK_CYCLES,
  parameter int unsigned          HEARTBEAT_CYCLES = DEFAULT_HEARTBEAT_CYCLES,
  parameter bit                   AUTO_ISOLATE     = 1'b0
) (
  input  logic                         clock_12mhz,
  input  logic                         reset,
  uart_line_monitor_bridge_if.slave    lines,
  input  logic                         isolate,
  input  logic                         stuck_clear,
  output logic [NUM_LINES-1:0]         activity_led,
  output logic [NUM_LINES-1:0]         stuck,
  output logic                         heartbeat_led
);

  localparam int unsigned HB_W = cnt_width(HEARTBEAT_CYCLES - 1);
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] iso_sync;
  logic [SYNC_STAGES-1:0] clr_sync;
  logic                   isolate_q;
  logic                   clear_q;
  logic [NUM_LINES-1:0]   force_idle;
  logic [HB_W-1:0]        hb_cnt;

  assign isolate_q = iso_sync[SYNC_STAGES-1];
  assign clear_q   = clr_sync[SYNC_STAGES-1];

  // Isolation resets to asserted so lines stay idle until reset release has synchronised.
  always_ff @(posedge clock_12mhz or posedge reset) begin
    if (reset) begin
      iso_sync <= '1;
      clr_sync <= '0;
    end else begin
      iso_sync <= {iso_sync[SYNC_STAGES-2:0], isolate};
      clr_sync <= {clr_sync[SYNC_STAGES-2:0], stuck_clear};
    end
  end

  // Per-bit 2:1 mux; the select comes from flops, so a line switches once and cleanly.
  always_comb begin
    force_idle = {NUM_LINES{isolate_q}};
    if (AUTO_ISOLATE)
      force_idle = force_idle | stuck;
    lines.line_out = (force_idle & IDLE_LEVEL) | (~force_idle & lines.line_in);
  end

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    uart_line_monitor #(
      .SYNC_STAGES   (SYNC_STAGES),
      .IDLE_BIT      (IDLE_LEVEL[i]),
      .STRETCH_CYCLES(STRETCH_CYCLES),
      .BREAK_CYCLES  (BREAK_CYCLES)
    ) u_mon (
      .clk         (clock_12mhz),
      .rst         (reset),
      .line_raw    (lines.line_in[i]),
      .clear       (clear_q),
      .activity_led(activity_led[i]),
      .stuck       (stuck[i])
    );
  end

  always_ff @(posedge clock_12mhz or posedge reset) begin
    if (reset) begin
      hb_cnt        <= '0;
      heartbeat_led <= 1'b0;
    end else if (hb_cnt == HB_LAST) begin
      hb_cnt        <= '0;
      heartbeat_led <= ~heartbeat_led;
    end else begin
      hb_cnt <= hb_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_line_monitor_bridge.sv
// Bench for uart_line_monitor_bridge: two instances (auto-isolate off and on)
// share one stimulus; expectations come from a history-based reference model.
module tb_uart_line_monitor_bridge;

  localparam int STR  = 8;
  localparam int BRK  = 20;
  localparam int HB   = 5;
  localparam int MAXC = 1024;
  localparam logic [3:0] IDLE = 4'b1111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       isolate = 1'b0;
  logic       stuck_clear = 1'b0;
  logic [3:0] line_in = 4'b0000;
  logic [3:0] act0, stk0, act1, stk1;
  logic       hb0, hb1;

  uart_line_monitor_bridge_if #(.NUM_LINES(4)) bus0 ();
  uart_line_monitor_bridge_if #(.NUM_LINES(4)) bus1 ();
  assign bus0.line_in = line_in;
  assign bus1.line_in = line_in;

  uart_line_monitor_bridge #(
    .NUM_LINES(4), .SYNC_STAGES(2), .IDLE_LEVEL(4'b1111), .STRETCH_CYCLES(STR),
    .BREAK_CYCLES(BRK), .HEARTBEAT_CYCLES(HB), .AUTO_ISOLATE(1'b0)
  ) dut0 (
    .clock_12mhz(clk), .reset(reset), .lines(bus0), .isolate(isolate),
    .stuck_clear(stuck_clear), .activity_led(act0), .stuck(stk0), .heartbeat_led(hb0)
  );

  uart_line_monitor_bridge #(
    .NUM_LINES(4), .SYNC_STAGES(2), .IDLE_LEVEL(4'b1111), .STRETCH_CYCLES(STR),
    .BREAK_CYCLES(BRK), .HEARTBEAT_CYCLES(HB), .AUTO_ISOLATE(1'b1)
  ) dut1 (
    .clock_12mhz(clk), .reset(reset), .lines(bus1), .isolate(isolate),
    .stuck_clear(stuck_clear), .activity_led(act1), .stuck(stk1), .heartbeat_led(hb1)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n = 0;
  int hb_e = 0;

  // History of what each clock edge sampled, indexed by edge number.
  logic [3:0] in_h    [0:MAXC];
  bit         rs_h    [0:MAXC];
  bit         iso_h   [0:MAXC];
  bit         clr_h   [0:MAXC];
  logic [3:0] stuck_h [0:MAXC];

  // Synchronised line value after edge k: the input two edges back, idle around reset.
  function automatic logic [3:0] s_at(input int k);
    if (k < 1) return IDLE;
    if (rs_h[k] || rs_h[k-1]) return IDLE;
    return in_h[k-1];
  endfunction

  function automatic logic [3:0] ep(input int k);
    if (k < 1 || rs_h[k]) return 4'b0000;
    return s_at(k) ^ s_at(k-1);
  endfunction

  // LED on after edge k iff an edge was detected during one of the previous STR cycles.
  function automatic logic [3:0] exp_led(input int k);
    logic [3:0] acc;
    acc = 4'b0000;
    if (rs_h[k]) return acc;
    for (int j = k - 1; j >= k - STR && j >= 1; j--) begin
      acc |= ep(j);
      if (rs_h[j]) break;
    end
    return acc;
  endfunction

  // Line has been non-idle for at least BRK consecutive cycles before edge k.
  function automatic logic [3:0] held_full(input int k);
    logic [3:0] r;
    r = 4'b0000;
    if (rs_h[k] || k - BRK < 1) return r;
    for (int i = 0; i < 4; i++) begin
      r[i] = 1'b1;
      for (int j = k - 1; j >= k - BRK; j--)
        if (s_at(j)[i] == IDLE[i]) r[i] = 1'b0;
    end
    return r;
  endfunction

  function automatic bit clrq(input int m);
    if (m < 1 || rs_h[m] || rs_h[m-1]) return 1'b0;
    return clr_h[m-1];
  endfunction

  function automatic bit isoq(input int m);
    if (m < 1 || rs_h[m] || rs_h[m-1]) return 1'b1;
    return iso_h[m-1];
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s at edge %0d: observed=%b expected=%b", tag, n, obs, expv);
    end
  endtask

  task automatic check_all();
    logic [3:0] force1;
    logic [3:0] exp0, exp1;
    exp0   = isoq(n) ? IDLE : line_in;
    force1 = {4{isoq(n)}} | stuck_h[n];
    exp1   = (force1 & IDLE) | (~force1 & line_in);
    chk("line_out_auto0", bus0.line_out, exp0);
    chk("line_out_auto1", bus1.line_out, exp1);
    chk("activity_led0", act0, exp_led(n));
    chk("activity_led1", act1, exp_led(n));
    chk("stuck0", stk0, stuck_h[n]);
    chk("stuck1", stk1, stuck_h[n]);
    chk("heartbeat0", {3'b000, hb0}, {3'b000, 1'((hb_e / HB) % 2)});
    chk("heartbeat1", {3'b000, hb1}, {3'b000, 1'((hb_e / HB) % 2)});
  endtask

  task automatic tick();
    logic [3:0] full;
    @(posedge clk);
    if (n < MAXC) n++;
    in_h[n]  = line_in;
    rs_h[n]  = reset;
    iso_h[n] = isolate;
    clr_h[n] = stuck_clear;
    full     = held_full(n);
    for (int i = 0; i < 4; i++) begin
      if (rs_h[n]) stuck_h[n][i] = 1'b0;
      else if (full[i]) stuck_h[n][i] = 1'b1;
      else if (clrq(n - 1)) stuck_h[n][i] = 1'b0;
      else stuck_h[n][i] = stuck_h[n-1][i];
    end
    hb_e = reset ? 0 : hb_e + 1;
    #1;
    check_all();
  endtask

  task automatic ticks(input int cnt);
    for (int c = 0; c < cnt; c++) tick();
  endtask

  initial begin
    in_h[0] = IDLE; rs_h[0] = 1'b1; iso_h[0] = 1'b1; clr_h[0] = 1'b0; stuck_h[0] = 4'b0000;

    // Reset held with lines low: outputs idle, monitors quiet.
    ticks(3);
    chk("reset_line_out", bus0.line_out, 4'b1111);
    chk("reset_leds", act0, 4'b0000);
    reset = 1'b0;
    tick();
    chk("release_c1_isolated", bus0.line_out, 4'b1111);
    tick();
    chk("release_c2_forward", bus0.line_out, 4'b0000);
    line_in = 4'b1111;
    ticks(14);

    // Falling edge on line 0: LED rises on the third edge, then a second edge extends it.
    line_in[0] = 1'b0;
    ticks(2);
    chk("act_not_yet", {3'b000, act0[0]}, 4'b0000);
    tick();
    chk("act_rise", {3'b000, act0[0]}, 4'b0001);
    ticks(4);
    line_in[0] = 1'b1;
    ticks(14);

    // Line 1 held low past the break limit, released, then cleared.
    line_in[1] = 1'b0;
    ticks(25);
    chk("stuck_set", stk0, 4'b0010);
    line_in[1] = 1'b1;
    ticks(4);
    chk("stuck_sticky", stk0, 4'b0010);
    stuck_clear = 1'b1;
    tick();
    stuck_clear = 1'b0;
    ticks(5);
    chk("stuck_cleared", stk0, 4'b0000);

    // Hold line 1 again with traffic on line 0; clear while still held.
    line_in[1] = 1'b0;
    for (int c = 0; c < 23; c++) begin
      line_in[0] = 1'($urandom_range(0, 1));
      tick();
    end
    stuck_clear = 1'b1;
    ticks(2);
    stuck_clear = 1'b0;
    ticks(3);
    line_in = 4'b1111;
    stuck_clear = 1'b1;
    tick();
    stuck_clear = 1'b0;
    ticks(4);

    // Random traffic with isolation switched on and off mid-stream.
    for (int c = 0; c < 40; c++) begin
      line_in = 4'($urandom);
      if (c == 15) isolate = 1'b1;
      if (c == 25) isolate = 1'b0;
      tick();
    end
    line_in = 4'b1111;
    ticks(12);

    // Free run, then hold line 2 stuck and reset asynchronously mid-cycle.
    ticks(30);
    line_in = 4'b1011;
    ticks(24);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_line_out0", bus0.line_out, 4'b1111);
    chk("async_rst_line_out1", bus1.line_out, 4'b1111);
    chk("async_rst_act", act0, 4'b0000);
    chk("async_rst_stuck", stk1, 4'b0000);
    chk("async_rst_hb", {3'b000, hb0}, 4'b0000);
    ticks(2);
    reset = 1'b0;
    line_in = 4'b1111;

    // Long randomised soak with sparse toggles, isolation and clears.
    for (int c = 0; c < 150; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 9) == 0) line_in[i] = ~line_in[i];
      isolate     = ($urandom_range(0, 19) == 0);
      stuck_clear = ($urandom_range(0, 11) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
